ifetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and runs a variable-latency instruction-memory handshake.
- Buffers one fetched instruction and splits it into the fields decode latches when not stalled.
- Resolves jumps and branches from decode-stage control; no delay slot, so the wrong-path instruction is squashed.

---
 rtl/ifetch_stage_pkg.sv | 43 ++++
 rtl/ifetch_stage_if.sv | 18 +
 rtl/ifetch_stage_target.sv | 52 +++++
 rtl/ifetch_stage.sv | 146 ++++++++++++++
 tb/tb_ifetch_stage.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ifetch_stage_pkg.sv
//------------------------------------------------------------------------------
// Module : dlx_fetch_pkg
// Brief  : Shared types and encodings for the DLX instruction-fetch stage.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dlx_fetch_pkg;

    typedef enum logic [1:0] {
        JT_NONE = 2'b00,
        JT_BR   = 2'b01,
        JT_J    = 2'b10,
        JT_JR   = 2'b11
    } jump_type_e;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        SKID = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [5:0]  OP_RTYPE  = 6'h00;
    localparam logic [5:0]  OP_FRTYPE = 6'h01;

    // Field LSB positions in conventional [31:0] numbering (big-endian bit 0 is word[31]).
    localparam int OP_LSB  = 26;
    localparam int RS1_LSB = 21;
    localparam int RS2_LSB = 16;
    localparam int RD_LSB  = 11;
    localparam int IMM_LSB = 0;
    localparam int FN_LSB  = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        valid;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_stage_if.sv
//------------------------------------------------------------------------------
// Module : ifetch_stage_if
// Brief  : Instruction-memory request/ready handshake between fetch and memory.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ifetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

`default_nettype wire

// File: rtl/ifetch_stage_target.sv
//------------------------------------------------------------------------------
// Module : fetch_target_calc
// Brief  : Combinational taken/target resolution for the instruction held by decode.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_target_calc
    import dlx_fetch_pkg::*;
(
    input  wire logic [25:0] shadow_offs,
    input  wire logic [31:0] shadow_pcp4,
    input  wire logic [1:0]  jump_type,
    input  wire logic        branch_cond,
    input  wire logic        cond_src,
    input  wire logic [31:0] cond_val,
    input  wire logic        fp_cond,
    input  wire logic [31:0] jump_reg_val,
    output logic             taken,
    output logic [31:0]      target
);
    logic        cond_nz;
    logic [31:0] raw_target;

    always_comb begin
        cond_nz    = cond_src ? fp_cond : (|cond_val);
        taken      = 1'b0;
        raw_target = jump_reg_val;
        case (jump_type)
            JT_BR: begin
                taken      = (cond_nz == branch_cond);
                raw_target = shadow_pcp4 + {{16{shadow_offs[15]}}, shadow_offs[15:0]};
            end
            JT_J: begin
                taken      = 1'b1;
                raw_target = shadow_pcp4 + {{6{shadow_offs[25]}}, shadow_offs};
            end
            JT_JR: begin
                taken      = 1'b1;
                raw_target = jump_reg_val;
            end
            default: begin
                taken      = 1'b0;
                raw_target = jump_reg_val;
            end
        endcase
        // Instructions are word aligned; the two low address bits are never fetched.
        target = {raw_target[31:2], 2'b00};
    end
endmodule

`default_nettype wire

// File: rtl/ifetch_stage.sv
//------------------------------------------------------------------------------
// Module : ifetch_stage
// Brief  : PC owner, variable-latency imem handshake, one-deep buffer with skid.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifetch_stage
    import dlx_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        stall,
    input  wire logic [1:0]  JumpType,
    input  wire logic        BranchCond,
    input  wire logic        CondSrc,
    input  wire logic [31:0] CondVal,
    input  wire logic        FPCond,
    input  wire logic [31:0] JumpRegVal,
    ifetch_stage_if.master   imem,
    output logic [5:0]       NextOpCode,
    output logic [4:0]       NextRs1,
    output logic [4:0]       NextRs2,
    output logic [4:0]       NextRd,
    output logic [15:0]      NextImmd,
    output logic [5:0]       NextFunction,
    output logic [31:0]      NextPCPlusFour
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, drop_addr_q, drop_addr_d;
    fetch_entry_t buf_q, buf_d, skid_q, skid_d, shadow_q, shadow_d;

    logic        w_taken, w_redirect, w_consume, w_buf_free, w_present;
    logic [31:0] w_target, w_pc_plus4, w_word;

    fetch_target_calc u_target (
        .shadow_offs  (shadow_q.instr[25:0]),
        .shadow_pcp4  (shadow_q.pcp4),
        .jump_type    (JumpType),
        .branch_cond  (BranchCond),
        .cond_src     (CondSrc),
        .cond_val     (CondVal),
        .fp_cond      (FPCond),
        .jump_reg_val (JumpRegVal),
        .taken        (w_taken),
        .target       (w_target)
    );

    assign w_consume  = ~stall;
    assign w_redirect = w_consume & shadow_q.valid & w_taken;
    assign w_buf_free = ~buf_q.valid | w_consume;
    assign w_pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        buf_d       = buf_q;
        skid_d      = skid_q;
        shadow_d    = shadow_q;

        // Decode sees a squashed bubble on a redirect edge, so the shadow must too.
        if (w_consume) begin
            shadow_d = w_redirect ? '0 : buf_q;
            buf_d    = '0;
        end

        case (state_q)
            REQ: begin
                if (w_redirect) begin
                    pc_d  = w_target;
                    buf_d = '0;
                    if (!imem.imem_ready) begin
                        drop_addr_d = pc_q;
                        state_d     = DROP;
                    end
                end else if (imem.imem_ready) begin
                    pc_d = w_pc_plus4;
                    if (w_buf_free) begin
                        buf_d = '{instr: imem.imem_rdata, pcp4: w_pc_plus4, valid: 1'b1};
                    end else begin
                        skid_d  = '{instr: imem.imem_rdata, pcp4: w_pc_plus4, valid: 1'b1};
                        state_d = SKID;
                    end
                end
            end
            SKID: begin
                if (w_consume) begin
                    if (w_redirect) begin
                        buf_d = '0;
                        pc_d  = w_target;
                    end else begin
                        buf_d = skid_q;
                    end
                    skid_d  = '0;
                    state_d = REQ;
                end
            end
            DROP: begin
                if (w_redirect) begin
                    pc_d = w_target;
                end
                if (imem.imem_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            buf_q       <= '0;
            skid_q      <= '0;
            shadow_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            buf_q       <= buf_d;
            skid_q      <= skid_d;
            shadow_q    <= shadow_d;
        end
    end

    assign imem.imem_req  = ~reset & (state_q != SKID);
    assign imem.imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;

    assign w_present      = buf_q.valid & ~w_redirect;
    assign w_word         = w_present ? buf_q.instr : NOP_WORD;
    assign NextOpCode     = w_word[OP_LSB +: 6];
    assign NextRs1        = w_word[RS1_LSB +: 5];
    assign NextRs2        = w_word[RS2_LSB +: 5];
    assign NextRd         = ((w_word[OP_LSB +: 6] == OP_RTYPE) || (w_word[OP_LSB +: 6] == OP_FRTYPE))
                            ? w_word[RD_LSB +: 5] : w_word[RS2_LSB +: 5];
    assign NextImmd       = w_word[IMM_LSB +: 16];
    assign NextFunction   = w_word[FN_LSB +: 6];
    assign NextPCPlusFour = w_present ? buf_q.pcp4 : 32'd0;
endmodule

`default_nettype wire

// File: tb/tb_ifetch_stage.sv
//------------------------------------------------------------------------------
// Module : tb_ifetch_stage
// Brief  : Directed bench for ifetch_stage with a latency-programmable memory.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ifetch_stage;
    localparam logic [1:0] C_JT_NONE = 2'b00;
    localparam logic [1:0] C_JT_BR   = 2'b01;
    localparam logic [1:0] C_JT_J    = 2'b10;
    localparam logic [1:0] C_JT_JR   = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  JumpType;
    logic        BranchCond, CondSrc, FPCond;
    logic [31:0] CondVal, JumpRegVal;
    logic [5:0]  NextOpCode, NextFunction;
    logic [4:0]  NextRs1, NextRs2, NextRd;
    logic [15:0] NextImmd;
    logic [31:0] NextPCPlusFour;

    int n_cmp = 0;
    int n_err = 0;
    int mem_lat = 0;
    int mem_cnt = 0;

    ifetch_stage_if imem_if ();

    ifetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .JumpType       (JumpType),
        .BranchCond     (BranchCond),
        .CondSrc        (CondSrc),
        .CondVal        (CondVal),
        .FPCond         (FPCond),
        .JumpRegVal     (JumpRegVal),
        .imem           (imem_if),
        .NextOpCode     (NextOpCode),
        .NextRs1        (NextRs1),
        .NextRs2        (NextRs2),
        .NextRd         (NextRd),
        .NextImmd       (NextImmd),
        .NextFunction   (NextFunction),
        .NextPCPlusFour (NextPCPlusFour)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0108: mem_word = {6'h00, 5'd3, 5'd4, 5'd5, 5'd0, 6'h20};
            32'h0000_01FC: mem_word = {6'h04, 5'd0, 5'd0, 16'hFFF0};
            32'hFFFF_FFEC: mem_word = {6'h02, 26'h3FF_FFFC};
            default:       mem_word = {6'h08, 5'd1, 5'd2, a[15:0]};
        endcase
    endfunction

    assign imem_if.imem_ready = imem_if.imem_req && (mem_cnt >= mem_lat);
    assign imem_if.imem_rdata = mem_word(imem_if.imem_addr);

    // Reset abandons any outstanding response.
    always @(posedge clk or posedge reset) begin
        if (reset)                                      mem_cnt <= 0;
        else if (imem_if.imem_req && imem_if.imem_ready) mem_cnt <= 0;
        else if (imem_if.imem_req)                      mem_cnt <= mem_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; JumpType = C_JT_NONE;
        BranchCond = 1'b0; CondSrc = 1'b0; FPCond = 1'b0;
        CondVal = 32'd0; JumpRegVal = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req",  {31'd0, imem_if.imem_req}, 32'd0);
        chk("rst_pcp4", NextPCPlusFour, 32'd0);
        chk("rst_opc",  {26'd0, NextOpCode}, 32'd0);

        reset = 1'b0; #1;
        chk("seq_addr0", imem_if.imem_addr, 32'h100);
        chk("seq_req0",  {31'd0, imem_if.imem_req}, 32'd1);
        step();
        chk("seq_addr1", imem_if.imem_addr, 32'h104);
        chk("seq_pcp4a", NextPCPlusFour, 32'h104);
        chk("seq_immd",  {16'd0, NextImmd}, 32'h0100);
        chk("seq_rd_i",  {27'd0, NextRd}, 32'd2);
        step();
        chk("seq_addr2", imem_if.imem_addr, 32'h108);
        chk("seq_pcp4b", NextPCPlusFour, 32'h108);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("skid_req",  {31'd0, imem_if.imem_req}, 32'd0);
            chk("skid_hold", NextPCPlusFour, 32'h108);
        end
        stall = 1'b0;
        step();
        chk("skid_out",  NextPCPlusFour, 32'h10C);
        chk("skid_rd_r", {27'd0, NextRd}, 32'd5);
        chk("skid_fn",   {26'd0, NextFunction}, 32'h20);
        chk("skid_addr", imem_if.imem_addr, 32'h10C);
        step();
        chk("skid_next", NextPCPlusFour, 32'h110);

        JumpType = C_JT_JR; JumpRegVal = 32'h0000_01FC; #1;
        chk("jr_squash", NextPCPlusFour, 32'd0);
        step(); JumpType = C_JT_NONE;
        chk("jr_addr",   imem_if.imem_addr, 32'h1FC);
        chk("jr_bubble", NextPCPlusFour, 32'd0);
        step();
        chk("br_ld_pcp4", NextPCPlusFour, 32'h200);
        chk("br_ld_imm",  {16'd0, NextImmd}, 32'hFFF0);
        step();
        JumpType = C_JT_BR; BranchCond = 1'b0; CondSrc = 1'b0; CondVal = 32'd0; #1;
        chk("br_squash", NextPCPlusFour, 32'd0);
        step(); JumpType = C_JT_NONE;
        chk("br_addr",   imem_if.imem_addr, 32'h1F0);
        chk("br_bubble", NextPCPlusFour, 32'd0);

        repeat (5) step();
        chk("br2_pre", NextPCPlusFour, 32'h204);
        JumpType = C_JT_BR; CondVal = 32'd5; #1;
        chk("brnt_keep", NextPCPlusFour, 32'h204);
        step(); JumpType = C_JT_NONE;
        chk("brnt_addr", imem_if.imem_addr, 32'h208);
        chk("brnt_pcp4", NextPCPlusFour, 32'h208);

        mem_lat = 3;
        JumpType = C_JT_JR; JumpRegVal = 32'h0000_0403;
        step(); JumpType = C_JT_NONE;
        for (int i = 0; i < 3; i++) begin
            chk("drop_addr", imem_if.imem_addr, 32'h208);
            chk("drop_req",  {31'd0, imem_if.imem_req}, 32'd1);
            chk("drop_out",  NextPCPlusFour, 32'd0);
            step();
        end
        chk("drop_new",  imem_if.imem_addr, 32'h400);
        chk("drop_disc", NextPCPlusFour, 32'd0);
        mem_lat = 0;
        step();
        chk("jr4_pcp4", NextPCPlusFour, 32'h404);
        chk("jr4_addr", imem_if.imem_addr, 32'h404);

        step();
        JumpType = C_JT_JR; JumpRegVal = 32'hFFFF_FFEC;
        step(); JumpType = C_JT_NONE;
        chk("jw_addr", imem_if.imem_addr, 32'hFFFF_FFEC);
        step();
        chk("jw_opc",  {26'd0, NextOpCode}, 32'd2);
        chk("jw_pcp4", NextPCPlusFour, 32'hFFFF_FFF0);
        step();
        JumpType = C_JT_J;
        step(); JumpType = C_JT_NONE;
        chk("jw_target", imem_if.imem_addr, 32'hFFFF_FFEC);
        chk("jw_bubble", NextPCPlusFour, 32'd0);

        stall = 1'b1;
        step();
        step();
        chk("rs_skid_req",  {31'd0, imem_if.imem_req}, 32'd0);
        chk("rs_skid_pcp4", NextPCPlusFour, 32'hFFFF_FFF0);
        reset = 1'b1; #1;
        chk("rs_req",  {31'd0, imem_if.imem_req}, 32'd0);
        chk("rs_pcp4", NextPCPlusFour, 32'd0);
        step();
        reset = 1'b0; stall = 1'b0; #1;
        chk("rs_addr", imem_if.imem_addr, 32'h100);
        chk("rs_req1", {31'd0, imem_if.imem_req}, 32'd1);
        step();
        chk("rs_pcp4a", NextPCPlusFour, 32'h104);
        chk("rs_immd",  {16'd0, NextImmd}, 32'h0100);
        step();
        chk("rs_pcp4b", NextPCPlusFour, 32'h108);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
